// File: rtl/branch_target_predictor_if.sv
// rtl/branch_target_predictor_if.sv - fetch lookup, resolve update and status signals of the branch target predictor
interface branch_target_predictor_if #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6
);
    logic [ADDR_W-1:0] pred_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic [IDX_W-1:0]  pred_ghr;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic [IDX_W-1:0]  upd_ghr;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_mispred;
    logic              ready;
    logic [31:0]       stat_br;
    logic [31:0]       stat_miss;

    modport master (
        output pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispred,
        input  pred_hit, pred_taken, pred_target, pred_ghr, ready, stat_br, stat_miss
    );

    modport slave (
        input  pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispred,
        output pred_hit, pred_taken, pred_target, pred_ghr, ready, stat_br, stat_miss
    );
endinterface

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - BTB with saturating direction counters, reset sweep and perf counters
// Optional gshare indexing is enabled by defining BTP_GSHARE_EN.
module branch_target_predictor #(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 2
) (
    input logic                    clk,
    input logic                    rst,
    branch_target_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = {1'b1, {(CTR_W-1){1'b0}}};

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t state, state_nxt;
    logic [IDX_W-1:0] sweep_idx;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];

    logic [IDX_W-1:0] ghr;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] pred_tag;
    logic [TAG_W-1:0] upd_tag;
    logic             ready;
    logic             upd_acc;
    logic             upd_hit;
    logic [31:0]      stat_br;
    logic [31:0]      stat_miss;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_valid;
    logic [TAG_W-1:0]  wr_tag;
    logic [ADDR_W-1:0] wr_target;
    logic [CTR_W-1:0]  wr_ctr;

    assign ready    = (state == S_RUN);
    assign upd_acc  = bus.upd_valid & ready;
    assign pred_tag = bus.pred_pc[ADDR_W-1:IDX_W+2];
    assign upd_tag  = bus.upd_pc[ADDR_W-1:IDX_W+2];

`ifdef BTP_GSHARE_EN
    logic unused_bits;
    assign unused_bits = ^{bus.pred_pc[1:0], bus.upd_pc[1:0]};
    assign pred_idx    = bus.pred_pc[IDX_W+1:2] ^ ghr;
    assign upd_idx     = bus.upd_pc[IDX_W+1:2] ^ bus.upd_ghr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (upd_acc) begin
            ghr <= {ghr[IDX_W-2:0], bus.upd_taken};
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{bus.pred_pc[1:0], bus.upd_pc[1:0], bus.upd_ghr};
    assign pred_idx    = bus.pred_pc[IDX_W+1:2];
    assign upd_idx     = bus.upd_pc[IDX_W+1:2];
    assign ghr         = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (sweep_idx == {IDX_W{1'b1}}) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_idx <= '0;
        end else if (state == S_INIT) begin
            sweep_idx <= sweep_idx + 1'b1;
        end
    end

    // Lookups read the flops only, so a same-cycle update to the same index is not seen yet.
    always_comb begin
        bus.pred_hit    = ready & valid_q[pred_idx] & (tag_q[pred_idx] == pred_tag);
        bus.pred_taken  = bus.pred_hit & ctr_q[pred_idx][CTR_W-1];
        bus.pred_target = bus.pred_hit ? target_q[pred_idx] : '0;
        bus.pred_ghr    = ghr;
    end

    assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);

    // One write port shared by the sweep and resolved updates; they never overlap.
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = upd_idx;
        wr_valid  = 1'b1;
        wr_tag    = upd_tag;
        wr_target = bus.upd_target;
        wr_ctr    = CTR_WEAK_T;
        if (state == S_INIT) begin
            wr_en     = 1'b1;
            wr_idx    = sweep_idx;
            wr_valid  = 1'b0;
            wr_tag    = '0;
            wr_target = '0;
            wr_ctr    = CTR_WEAK_NT;
        end else if (upd_acc && upd_hit) begin
            wr_en = 1'b1;
            if (bus.upd_taken) begin
                wr_ctr = (ctr_q[upd_idx] == {CTR_W{1'b1}}) ? ctr_q[upd_idx] : ctr_q[upd_idx] + 1'b1;
            end else begin
                wr_target = target_q[upd_idx];
                wr_ctr    = (ctr_q[upd_idx] == '0) ? ctr_q[upd_idx] : ctr_q[upd_idx] - 1'b1;
            end
        end else if (upd_acc && bus.upd_taken) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            valid_q[wr_idx]  <= wr_valid;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
            ctr_q[wr_idx]    <= wr_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br   <= '0;
            stat_miss <= '0;
        end else if (upd_acc) begin
            stat_br   <= stat_br + 32'd1;
            stat_miss <= stat_miss + {31'd0, bus.upd_mispred};
        end
    end

    assign bus.ready     = ready;
    assign bus.stat_br   = stat_br;
    assign bus.stat_miss = stat_miss;
endmodule
